register_file_mp: RTL and testbench

- Parametrised multi-read-port register file, successor to the 32x32 dual-read bank.
- Adds:
  - a configurable number of read ports;
  - write-to-read bypass;
  - a hardware clear sequence after reset;
  - a per-register busy scoreboard for multi-cycle hazard tracking.
- Sits between the control/decode stage and the ALU operand muxes of the RV32I core.

---
 rtl/register_file_mp.sv | 187 ++++++++++++++++++
 tb/tb_register_file_mp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//
// Parametrised multi-read-port register file placed between decode and the
// ALU operand muxes. After every reset a hardware sequence writes zero into
// one register per cycle; only then does the bank accept writes and return
// read data. A per-register busy scoreboard tracks results still in flight.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous active-high reset
//   reg_we_i       write enable, active-low
//   data_i         write data
//   reg_dst_i      write destination select
//   reserve_i      active-high, mark reserve_dst_i busy
//   reserve_dst_i  register to reserve
//   reg_src_i      packed read selects, port p at [p*SELECT_SIZE +: SELECT_SIZE]
//   src_o          packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   busy_o         busy bit of the register selected by each read port
//   ready_o        high once the clear sequence has completed
// ---------------------------------------------------------------------------
module register_file_mp #(
    parameter int DATA_WIDTH  = 32,
    parameter int WORDS       = 32,
    parameter int SELECT_SIZE = 5,
    parameter int READ_PORTS  = 2,
    parameter int ZERO_REG    = 1,
    parameter int BYPASS      = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              reg_we_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    input  logic [SELECT_SIZE-1:0]            reg_dst_i,
    input  logic                              reserve_i,
    input  logic [SELECT_SIZE-1:0]            reserve_dst_i,
    input  logic [READ_PORTS*SELECT_SIZE-1:0] reg_src_i,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  src_o,
    output logic [READ_PORTS-1:0]             busy_o,
    output logic                              ready_o
);

    // Bank index width; selects are truncated to this once range-checked.
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    // One extra bit so WORDS == 2**SELECT_SIZE is representable.
    localparam logic [SELECT_SIZE:0] WORDS_L  = (SELECT_SIZE + 1)'(WORDS);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WORDS - 1);
    localparam bit                   ZR       = (ZERO_REG != 0);
    localparam bit                   BP       = (BYPASS != 0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [IDX_W-1:0]        clr_cnt_r;
    logic [DATA_WIDTH-1:0]   bank_r [0:WORDS-1];
    logic [WORDS-1:0]        busy_r;
    logic [WORDS-1:0]        busy_nxt_s;
    logic                    run_s;
    logic                    wr_en_s;
    logic                    rsv_en_s;
    logic [IDX_W-1:0]        wr_idx_s;
    logic [IDX_W-1:0]        rsv_idx_s;

    // A select addresses real storage: inside the bank and not the
    // hardwired zero register.
    function automatic logic sel_valid(input logic [SELECT_SIZE-1:0] sel);
        return ({1'b0, sel} < WORDS_L) && !(ZR && (sel == {SELECT_SIZE{1'b0}}));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [SELECT_SIZE-1:0] sel);
        return IDX_W'(sel);
    endfunction

    assign run_s     = (state_r == ST_RUN);
    assign ready_o   = run_s;
    assign wr_idx_s  = to_idx(reg_dst_i);
    assign rsv_idx_s = to_idx(reserve_dst_i);
    // Writes and reservations are only honoured once the clear has finished.
    assign wr_en_s   = run_s && !reg_we_i && sel_valid(reg_dst_i);
    assign rsv_en_s  = run_s && reserve_i && sel_valid(reserve_dst_i);

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: leave CLEAR on the cycle that clears the last index.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN:   state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_CLEAR;
        endcase
    end

    // Clear-sequence index, restarts from zero on every reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_cnt_r <= IDX_W'(0);
        end else if (state_r == ST_CLEAR) begin
            if (clr_cnt_r == LAST_IDX) begin
                clr_cnt_r <= IDX_W'(0);
            end else begin
                clr_cnt_r <= clr_cnt_r + IDX_W'(1);
            end
        end else begin
            clr_cnt_r <= clr_cnt_r;
        end
    end

    // Storage: zero-fill during CLEAR, normal writes during RUN. No reset
    // here on purpose; the clear sequence is what initialises the bank.
    always_ff @(posedge clk_i) begin
        if (state_r == ST_CLEAR) begin
            bank_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
        end else if (wr_en_s) begin
            bank_r[wr_idx_s] <= data_i;
        end
    end

    // Scoreboard next value; the reserve is applied last so it wins over a
    // clearing write to the same register.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wr_en_s) begin
            busy_nxt_s[wr_idx_s] = 1'b0;
        end else begin
            busy_nxt_s[wr_idx_s] = busy_r[wr_idx_s];
        end
        if (rsv_en_s) begin
            busy_nxt_s[rsv_idx_s] = 1'b1;
        end else begin
            busy_nxt_s[rsv_idx_s] = busy_nxt_s[rsv_idx_s];
        end
    end

    // Scoreboard register, held clear until the bank is running.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_r <= {WORDS{1'b0}};
        end else if (run_s) begin
            busy_r <= busy_nxt_s;
        end else begin
            busy_r <= {WORDS{1'b0}};
        end
    end

    // Read ports: zero when not running or selecting no real register,
    // otherwise forward a same-cycle write (if enabled) or read the bank.
    // busy_o is taken from registered state and never forwarded.
    always_comb begin
        logic [SELECT_SIZE-1:0] sel;
        sel    = {SELECT_SIZE{1'b0}};
        src_o  = {(READ_PORTS*DATA_WIDTH){1'b0}};
        busy_o = {READ_PORTS{1'b0}};
        for (int p = 0; p < READ_PORTS; p++) begin
            sel = reg_src_i[p*SELECT_SIZE +: SELECT_SIZE];
            if (run_s && sel_valid(sel)) begin
                if (BP && wr_en_s && (reg_dst_i == sel)) begin
                    src_o[p*DATA_WIDTH +: DATA_WIDTH] = data_i;
                end else begin
                    src_o[p*DATA_WIDTH +: DATA_WIDTH] = bank_r[to_idx(sel)];
                end
                busy_o[p] = busy_r[to_idx(sel)];
            end else begin
                src_o[p*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
                busy_o[p] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
//
// Two instances share clock, reset and write/reserve inputs:
//   dut_a : WORDS=32, 4 read ports, ZERO_REG=1, BYPASS=1
//   dut_b : WORDS=16, 2 read ports, ZERO_REG=0, BYPASS=0
// Inputs change 1 time unit after a rising edge; outputs are checked there
// too, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_register_file_mp;

    logic         clk;
    logic         rst;
    logic         we_n;
    logic [31:0]  data;
    logic [4:0]   dst;
    logic         rsv;
    logic [4:0]   rsv_dst;
    logic [19:0]  sel_a;
    logic [127:0] src_a;
    logic [3:0]   busy_a;
    logic         ready_a;
    logic [9:0]   sel_b;
    logic [63:0]  src_b;
    logic [1:0]   busy_b;
    logic         ready_b;

    int vectors;
    int miscompares;
    int na;
    int nb;

    register_file_mp #(
        .DATA_WIDTH(32), .WORDS(32), .SELECT_SIZE(5),
        .READ_PORTS(4), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .reg_we_i(we_n), .data_i(data),
        .reg_dst_i(dst), .reserve_i(rsv), .reserve_dst_i(rsv_dst),
        .reg_src_i(sel_a), .src_o(src_a), .busy_o(busy_a), .ready_o(ready_a)
    );

    register_file_mp #(
        .DATA_WIDTH(32), .WORDS(16), .SELECT_SIZE(5),
        .READ_PORTS(2), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .reg_we_i(we_n), .data_i(data),
        .reg_dst_i(dst), .reserve_i(rsv), .reserve_dst_i(rsv_dst),
        .reg_src_i(sel_b), .src_o(src_b), .busy_o(busy_b), .ready_o(ready_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run until dut_a is ready, recording the cycle each instance came up.
    task automatic count_clear();
        na = 0;
        nb = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready_b && (nb == 0)) nb = i;
            if (ready_a) begin
                na = i;
                break;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        we_n    = 1'b1;
        data    = 32'h0;
        dst     = 5'd0;
        rsv     = 1'b0;
        rsv_dst = 5'd0;
        sel_a   = 20'h0;
        sel_b   = 10'h0;

        // Outputs held quiet during reset.
        tick();
        tick();
        chk("rst_ready_a", {127'h0, ready_a}, 128'h0);
        chk("rst_ready_b", {127'h0, ready_b}, 128'h0);
        chk("rst_src_a", src_a, 128'h0);
        chk("rst_busy_a", {124'h0, busy_a}, 128'h0);

        // Partial clear, then reset again at counter=10 with a write held.
        rst = 1'b0;
        repeat (10) tick();
        chk("clr10_ready_a", {127'h0, ready_a}, 128'h0);
        rst  = 1'b1;
        we_n = 1'b0;
        dst  = 5'd5;
        data = 32'h0000_1234;
        #1;
        chk("midclr_rst_src_a", src_a, 128'h0);
        tick();
        rst = 1'b0;
        count_clear();
        we_n = 1'b1;
        chk("clear_len_a", 128'(na), 128'd32);
        chk("clear_len_b", 128'(nb), 128'd16);

        // Every register zero. dut_b ran the held x5 write after its own
        // 16-cycle clear, so x5 holds 0x1234 there; out-of-range reads 0.
        for (int r = 0; r < 32; r++) begin
            sel_a = {4{r[4:0]}};
            sel_b = {2{r[4:0]}};
            #1;
            chk("sweep_a", src_a, 128'h0);
            chk("sweep_b", {64'h0, src_b}, (r == 5) ? {64'h0, {2{32'h0000_1234}}} : 128'h0);
        end

        // Write x14 with every port selecting it.
        sel_a = {4{5'd14}};
        sel_b = {2{5'd14}};
        we_n  = 1'b0;
        dst   = 5'd14;
        data  = 32'hBEEF_DEAD;
        #1;
        chk("byp_same_a", src_a, {4{32'hBEEF_DEAD}});
        chk("nobyp_same_b", {64'h0, src_b}, 128'h0);
        tick();
        we_n = 1'b1;
        #1;
        chk("byp_after_a", src_a, {4{32'hBEEF_DEAD}});
        chk("nobyp_after_b", {64'h0, src_b}, {64'h0, {2{32'hBEEF_DEAD}}});

        // Write and reserve x0 together.
        sel_a   = 20'h0;
        sel_b   = 10'h0;
        we_n    = 1'b0;
        dst     = 5'd0;
        data    = 32'hFFFF_FFFF;
        rsv     = 1'b1;
        rsv_dst = 5'd0;
        #1;
        chk("x0_same_a", src_a, 128'h0);
        chk("x0_same_b", {64'h0, src_b}, 128'h0);
        tick();
        we_n = 1'b1;
        rsv  = 1'b0;
        #1;
        chk("x0_after_a", src_a, 128'h0);
        chk("x0_busy_a", {124'h0, busy_a}, 128'h0);
        chk("x0_after_b", {64'h0, src_b}, {64'h0, {2{32'hFFFF_FFFF}}});
        chk("x0_busy_b", {126'h0, busy_b}, {126'h0, 2'b11});

        // Scoreboard on x7.
        sel_a   = {4{5'd7}};
        sel_b   = {2{5'd7}};
        rsv     = 1'b1;
        rsv_dst = 5'd7;
        #1;
        chk("rsv_same_a", {124'h0, busy_a}, 128'h0);
        tick();
        rsv = 1'b0;
        #1;
        chk("rsv_next_a", {124'h0, busy_a}, {124'h0, 4'hF});
        chk("rsv_next_b", {126'h0, busy_b}, {126'h0, 2'b11});
        we_n = 1'b0;
        dst  = 5'd7;
        data = 32'h0000_0077;
        #1;
        chk("wr7_busy_same_a", {124'h0, busy_a}, {124'h0, 4'hF});
        chk("wr7_src_same_a", src_a, {4{32'h0000_0077}});
        tick();
        we_n = 1'b1;
        #1;
        chk("wr7_busy_after_a", {124'h0, busy_a}, 128'h0);
        chk("wr7_busy_after_b", {126'h0, busy_b}, 128'h0);
        chk("wr7_src_after_b", {64'h0, src_b}, {64'h0, {2{32'h0000_0077}}});
        we_n = 1'b0;
        data = 32'h0000_0099;
        rsv  = 1'b1;
        tick();
        we_n = 1'b1;
        rsv  = 1'b0;
        #1;
        chk("rsvwr_busy_a", {124'h0, busy_a}, {124'h0, 4'hF});
        chk("rsvwr_src_a", src_a, {4{32'h0000_0099}});
        chk("rsvwr_busy_b", {126'h0, busy_b}, {126'h0, 2'b11});

        // Preload x1..x4 with 1..4 and x31 with 0x31 (suppressed in dut_b).
        for (int r = 1; r <= 4; r++) begin
            we_n = 1'b0;
            dst  = 5'(r);
            data = 32'(r);
            tick();
        end
        dst  = 5'd31;
        data = 32'h0000_0031;
        tick();
        we_n  = 1'b1;
        sel_a = {5'd4, 5'd3, 5'd2, 5'd1};
        sel_b = {5'd2, 5'd1};
        #1;
        chk("ports4_a", src_a, {32'd4, 32'd3, 32'd2, 32'd1});
        chk("ports2_b", {64'h0, src_b}, {64'h0, 32'd2, 32'd1});
        sel_a = {5'd31, 5'd0, 5'd7, 5'd14};
        sel_b = {2{5'd31}};
        #1;
        chk("mix_a", src_a, {32'h0000_0031, 32'h0, 32'h0000_0099, 32'hBEEF_DEAD});
        chk("mix_busy_a", {124'h0, busy_a}, {124'h0, 4'b0010});
        chk("oor_b", {64'h0, src_b}, 128'h0);
        chk("oor_busy_b", {126'h0, busy_b}, 128'h0);

        // Reset mid-RUN: immediate quiet outputs, full clear repeats.
        sel_a = {5'd7, 5'd14, 5'd31, 5'd1};
        rst   = 1'b1;
        #1;
        chk("runrst_ready_a", {127'h0, ready_a}, 128'h0);
        chk("runrst_src_a", src_a, 128'h0);
        tick();
        rst = 1'b0;
        count_clear();
        chk("reclear_len_a", 128'(na), 128'd32);
        chk("reclear_len_b", 128'(nb), 128'd16);
        chk("reclear_src_a", src_a, 128'h0);
        chk("reclear_busy_a", {124'h0, busy_a}, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
